// File: rtl/systolic_mac_array.sv
// systolic_mac_array
//   Output-stationary systolic matrix-multiply engine computing C = A x B,
//   with A of size N x K and B of size K x N (N = ARRAY_SIZE, K set per job).
//   Operand beats are skewed internally, so beat k carries column k of A and
//   row k of B unskewed. Result rows are returned one per handshake.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start, k_len      job launch (sampled in IDLE) and inner dimension K
//   busy              high whenever the engine is not IDLE
//   in_valid/in_ready operand beat stream; in_d = column k of A, in_w = row k of B
//   out_valid/ready   result stream; out_row = row out_row_idx of C
//   done              one-cycle pulse after the handshake on the last row
//   dbg_state_o       current FSM state (IDLE=0, FEED=1, FLUSH=2, DRAIN=3)
//
// Build option
//   SYSTOLIC_SAT_EN   when defined, every accumulate saturates to the signed
//                     ACC_WIDTH range; otherwise it wraps in two's complement.
//
// Stream handshake: a beat or row transfers on a rising edge where valid and
// ready are both high. in_ready is a decode of the registered state only and
// never looks at in_valid; out_row/out_row_idx hold steady while out_ready
// is low.
module systolic_mac_array #(
    parameter int ARRAY_SIZE = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int K_WIDTH    = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [K_WIDTH-1:0]               k_len,
    output logic                             busy,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_d,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_w,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ARRAY_SIZE*ACC_WIDTH-1:0]  out_row,
    output logic [$clog2(ARRAY_SIZE)-1:0]    out_row_idx,
    output logic                             done,
    output logic [1:0]                       dbg_state_o
);
    localparam int N  = ARRAY_SIZE;
    localparam int RW = $clog2(N);
    localparam int FW = $clog2(2 * N);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 2);
    localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, FEED = 2'd1, FLUSH = 2'd2, DRAIN = 2'd3} state_t;

    state_t               state_q, state_d;
    logic [K_WIDTH-1:0]   k_q, beat_q;
    logic [FW-1:0]        flush_q;
    logic [RW-1:0]        row_q;
    logic                 done_q;

    logic [DATA_WIDTH-1:0] a_q   [N][N];
    logic [DATA_WIDTH-1:0] b_q   [N][N];
    logic [ACC_WIDTH-1:0]  acc_q [N][N];
    logic [DATA_WIDTH-1:0] a_in  [N][N];
    logic [DATA_WIDTH-1:0] b_in  [N][N];
    logic [DATA_WIDTH-1:0] d_lane[N], w_lane[N], d_skew[N], w_skew[N];

    logic start_acc, beat_acc, advance, last_beat, flush_last, row_hs, last_row;

    assign start_acc  = (state_q == IDLE) && start;
    assign beat_acc   = (state_q == FEED) && in_valid;
    assign advance    = beat_acc || (state_q == FLUSH);
    assign last_beat  = beat_acc && (beat_q == k_q - K_WIDTH'(1));
    assign flush_last = (state_q == FLUSH) && (flush_q == FLUSH_LAST);
    assign row_hs     = (state_q == DRAIN) && out_ready;
    assign last_row   = row_hs && (row_q == ROW_LAST);

    // Signed product, sign-extended, added to the accumulator.
    function automatic logic [ACC_WIDTH-1:0] mac(input logic [ACC_WIDTH-1:0] acc,
                                                 input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
        logic signed [2*DATA_WIDTH-1:0] prod;
        logic signed [ACC_WIDTH-1:0]    prod_ext;
`ifdef SYSTOLIC_SAT_EN
        logic [ACC_WIDTH:0]             sum;
        prod     = $signed(a) * $signed(b);
        prod_ext = ACC_WIDTH'(prod);
        sum      = {acc[ACC_WIDTH-1], acc} + {prod_ext[ACC_WIDTH-1], prod_ext};
        // Carry-out differing from the sign bit means the true sum left the range.
        if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1])
            return sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        return sum[ACC_WIDTH-1:0];
`else
        prod     = $signed(a) * $signed(b);
        prod_ext = ACC_WIDTH'(prod);
        return acc + prod_ext;
`endif
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (k_len == '0) ? FLUSH : FEED;
            FEED:    if (last_beat) state_d = FLUSH;
            FLUSH:   if (flush_last) state_d = DRAIN;
            DRAIN:   if (last_row) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- counters ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q     <= '0;
            beat_q  <= '0;
            flush_q <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= last_row;
            if (start_acc) begin
                k_q     <= k_len;
                beat_q  <= '0;
                flush_q <= '0;
                row_q   <= '0;
            end else begin
                if (beat_acc)           beat_q  <= beat_q + K_WIDTH'(1);
                if (state_q == FLUSH)   flush_q <= flush_q + FW'(1);
                if (row_hs)             row_q   <= last_row ? '0 : row_q + RW'(1);
            end
        end
    end

    // ---------------- input skew ----------------
    // Lane i of the data (and lane j of the weights) is delayed by i (j)
    // advances so that matching operands meet inside the array. Zeros are
    // injected outside FEED to flush the wavefront out.
    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_skew
            assign d_lane[gi] = (state_q == FEED) ? in_d[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
            assign w_lane[gi] = (state_q == FEED) ? in_w[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
            if (gi == 0) begin : g_direct
                assign d_skew[gi] = d_lane[gi];
                assign w_skew[gi] = w_lane[gi];
            end else begin : g_sr
                logic [DATA_WIDTH-1:0] dsr_q [gi];
                logic [DATA_WIDTH-1:0] wsr_q [gi];
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n || start_acc) begin
                        for (int s = 0; s < gi; s++) begin
                            dsr_q[s] <= '0;
                            wsr_q[s] <= '0;
                        end
                    end else if (advance) begin
                        dsr_q[0] <= d_lane[gi];
                        wsr_q[0] <= w_lane[gi];
                        for (int s = 1; s < gi; s++) begin
                            dsr_q[s] <= dsr_q[s-1];
                            wsr_q[s] <= wsr_q[s-1];
                        end
                    end
                end
                assign d_skew[gi] = dsr_q[gi-1];
                assign w_skew[gi] = wsr_q[gi-1];
            end
        end

        // Data enters from the left edge, weights from the top edge.
        for (gi = 0; gi < N; gi++) begin : g_row
            for (gj = 0; gj < N; gj++) begin : g_col
                if (gj == 0) begin : g_a_edge
                    assign a_in[gi][gj] = d_skew[gi];
                end else begin : g_a_pass
                    assign a_in[gi][gj] = a_q[gi][gj-1];
                end
                if (gi == 0) begin : g_b_edge
                    assign b_in[gi][gj] = w_skew[gj];
                end else begin : g_b_pass
                    assign b_in[gi][gj] = b_q[gi-1][gj];
                end
            end
        end
    endgenerate

    // ---------------- PE grid ----------------
    // Each PE multiplies the operands it registered on the previous advance,
    // so beat k lands in PE(i,j) on advance k+i+j+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || start_acc) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_q[i][j]   <= '0;
                    b_q[i][j]   <= '0;
                    acc_q[i][j] <= '0;
                end
            end
        end else if (advance) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_q[i][j]   <= a_in[i][j];
                    b_q[i][j]   <= b_in[i][j];
                    acc_q[i][j] <= mac(acc_q[i][j], a_q[i][j], b_q[i][j]);
                end
            end
        end
    end

    // ---------------- outputs ----------------
    assign busy        = (state_q != IDLE);
    assign in_ready    = (state_q == FEED);
    assign out_valid   = (state_q == DRAIN);
    assign out_row_idx = row_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

    always_comb begin
        out_row = '0;
        if (state_q == DRAIN) begin
            for (int j = 0; j < N; j++) out_row[j*ACC_WIDTH +: ACC_WIDTH] = acc_q[row_q][j];
        end
    end
endmodule

// File: tb/tb_systolic_mac_array.sv
module tb_systolic_mac_array;
    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int AW   = 16;
    localparam int KW   = 8;
    localparam int KMAX = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, start, busy, in_valid, in_ready, out_valid, out_ready, done;
    logic [KW-1:0]     k_len;
    logic [N*DW-1:0]   in_d, in_w;
    logic [N*AW-1:0]   out_row;
    logic [1:0]        out_row_idx;
    logic [1:0]        dbg_state;

    systolic_mac_array #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_WIDTH(KW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_d(in_d), .in_w(in_w),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_row_idx(out_row_idx), .done(done), .dbg_state_o(dbg_state)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic signed [DW-1:0] a_m [N][KMAX];
    logic signed [DW-1:0] b_m [KMAX][N];
    logic [N*AW-1:0] exp_q[$];
    int              exp_idx_q[$];

    function automatic longint acc_add(input longint acc, input longint p);
        longint s;
        s = acc + p;
`ifdef SYSTOLIC_SAT_EN
        if (s > (longint'(1) <<< (AW - 1)) - 1) s = (longint'(1) <<< (AW - 1)) - 1;
        else if (s < -(longint'(1) <<< (AW - 1))) s = -(longint'(1) <<< (AW - 1));
`else
        s = s & ((longint'(1) <<< AW) - 1);
        if (s >= (longint'(1) <<< (AW - 1))) s = s - (longint'(1) <<< AW);
`endif
        return s;
    endfunction

    task automatic push_expected(input int k);
        longint c;
        logic [N*AW-1:0] row;
        for (int r = 0; r < N; r++) begin
            row = '0;
            for (int j = 0; j < N; j++) begin
                c = 0;
                for (int kk = 0; kk < k; kk++)
                    c = acc_add(c, longint'(a_m[r][kk]) * longint'(b_m[kk][j]));
                row[j*AW +: AW] = c[AW-1:0];
            end
            exp_q.push_back(row);
            exp_idx_q.push_back(r);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    bit pending_done = 0;
    bit done_flag    = 0;
    int done_cyc     = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (pending_done) begin
                chk("done_pulse", {63'd0, done}, 64'd1);
                chk("busy_at_done", {63'd0, busy}, 64'd0);
                pending_done = 0;
            end else if (done) begin
                chk("spurious_done", {63'd0, done}, 64'd0);
            end
            if (done) begin
                done_flag = 1;
                done_cyc  = cyc;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_row", {63'd0, out_valid}, 64'd0);
                end else begin
                    chk("row", 64'(out_row), 64'(exp_q[0]));
                    chk("row_idx", 64'(out_row_idx), 64'(exp_idx_q[0]));
                    if (out_ready) begin
                        if (exp_idx_q[0] == N - 1) pending_done = 1;
                        void'(exp_q.pop_front());
                        void'(exp_idx_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- output-ready driver ----------------
    // 0: always ready, 1: random, 2: hold row 0 off for 5 cycles
    int out_mode = 0;
    int hold_cnt = 0;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (out_mode)
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (out_valid && out_row_idx == 2'd0 && hold_cnt < 5) begin
                        out_ready = 1'b0;
                        hold_cnt++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_beat(input int k);
        for (int i = 0; i < N; i++) in_d[i*DW +: DW] = a_m[i][k];
        for (int j = 0; j < N; j++) in_w[j*DW +: DW] = b_m[k][j];
    endtask

    // Called shortly after a rising edge with the engine idle.
    // stall: 0 none, 1 in_valid low on every other cycle (first low), 2 random
    task automatic run_job(input int k, input int stall, output int done_rel);
        int base, beat, fc, guard;
        logic vld, rdy;
        push_expected(k);
        done_flag = 0;
        start = 1'b1;
        k_len = KW'(k);
        @(posedge clk);
        #1;
        start = 1'b0;
        k_len = KW'($urandom_range(0, 255));
        base  = cyc - 1;
        beat  = 0;
        fc    = 0;
        while (beat < k && fc < 1000) begin
            case (stall)
                1:       vld = (fc % 2 == 1);
                2:       vld = ($urandom_range(0, 3) != 0);
                default: vld = 1'b1;
            endcase
            in_valid = vld;
            if (vld) drive_beat(beat);
            else begin
                in_d = N*DW'($urandom);
                in_w = N*DW'($urandom);
            end
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (vld && rdy) beat++;
            fc++;
        end
        in_valid = 1'b0;
        in_d = N*DW'($urandom);
        in_w = N*DW'($urandom);
        if (beat < k) chk("feed_timeout", 64'(beat), 64'(k));
        guard = 0;
        while (!done_flag && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("done_seen", {63'd0, done_flag}, 64'd1);
        done_rel = done_cyc - base;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        exp_idx_q.delete();
    endtask

    task automatic fill_identity();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                a_m[i][k] = DW'(4 * i + k + 1);
                b_m[k][i] = (i == k) ? DW'(1) : DW'(0);
            end
    endtask

    task automatic fill_const(input int av, input int bv);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < KMAX; k++) begin
                a_m[i][k] = DW'(av);
                b_m[k][i] = DW'(bv);
            end
    endtask

    // ---------------- main sequence ----------------
    int d;
    initial begin
        rst_n = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0; in_d = '0; in_w = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_row", 64'(out_row), 64'd0);
        chk("rst_row_idx", 64'(out_row_idx), 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // identity, no stalls: rows equal A, done 16 cycles after start
        fill_identity();
        chk("identity_row0_model", 64'({16'd4, 16'd3, 16'd2, 16'd1}),
            64'({16'(a_m[0][3]), 16'(a_m[0][2]), 16'(a_m[0][1]), 16'(a_m[0][0])}));
        run_job(4, 0, d);
        chk("identity_done_cycle", 64'(d), 64'd16);

        // signed extremes
        fill_const(-128, -128);
        run_job(4, 0, d);
        fill_const(-1, 1);
        run_job(4, 0, d);
        chk("neg_done_cycle", 64'(d), 64'd16);

        // alternating input stalls: four cycles later
        fill_identity();
        run_job(4, 1, d);
        chk("stall_done_cycle", 64'(d), 64'd20);

        // output backpressure on row 0 for five cycles
        out_mode = 2;
        hold_cnt = 0;
        run_job(4, 0, d);
        chk("bp_done_cycle", 64'(d), 64'd21);
        chk("bp_hold_cycles", 64'(hold_cnt), 64'd5);
        out_mode = 0;

        // large positive products: saturate or wrap depending on build
        fill_const(127, 127);
        run_job(4, 0, d);

        // empty job
        run_job(0, 0, d);
        chk("k0_done_cycle", 64'(d), 64'd12);

        // reset in the middle of FEED
        fill_identity();
        start = 1'b1;
        k_len = KW'(4);
        @(posedge clk);
        #1;
        start = 1'b0;
        in_valid = 1'b1;
        drive_beat(0);
        @(posedge clk);
        #1;
        drive_beat(1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_out_row", 64'(out_row), 64'd0);
        chk("midrst_state", 64'(dbg_state), 64'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_job(4, 0, d);
        chk("post_rst_done_cycle", 64'(d), 64'd16);

        // randomized jobs with random input stalls and output backpressure
        out_mode = 1;
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < N; i++)
                for (int k = 0; k < KMAX; k++) begin
                    a_m[i][k] = (t % 4 == 0) ? DW'($urandom_range(0, 1) ? 127 : 128) : DW'($urandom_range(0, 255));
                    b_m[k][i] = (t % 4 == 0) ? DW'($urandom_range(0, 1) ? 127 : 128) : DW'($urandom_range(0, 255));
                end
            run_job($urandom_range(1, KMAX), 2, d);
        end
        out_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/systolic_mac_array.md
# systolic_mac_array

Parametrised output-stationary systolic matrix-multiply engine, the successor to the fixed 32×32 array. It computes C = A×B for an ARRAY_SIZE×K data matrix A and a K×ARRAY_SIZE weight matrix B, where K is set at runtime. It skews its inputs internally and accepts operands through a valid/ready stream. It returns C one row at a time through a valid/ready result stream, and sits between the SRAM operand fetch logic and the post-processing/writeback stage.

## Interface
- ARRAY_SIZE, 8, PE rows = PE columns (N), ≥2
- DATA_WIDTH, 8, signed operand width
- ACC_WIDTH, 24, signed accumulator/result width, ≥ 2*DATA_WIDTH
- K_WIDTH, 8, width of k_len (max K = 2^K_WIDTH−1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  begin a job; sampled only in IDLE
- k_len  in  K_WIDTH  inner dimension K, latched on accepted start
- busy  out  1  high in every state except IDLE
- in_valid  in  1  operand beat valid
- in_ready  out  1  array can accept a beat
- in_d  in  N*DATA_WIDTH  column k of A; row i at [i*DATA_WIDTH +: DATA_WIDTH]
- in_w  in  N*DATA_WIDTH  row k of B; column j at [j*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  result row valid
- out_ready  in  1  consumer accepts row
- out_row  out  N*ACC_WIDTH  C[r][j] at [j*ACC_WIDTH +: ACC_WIDTH]
- out_row_idx  out  $clog2(N)  row index r of out_row
- done  out  1  one-cycle pulse after the last row handshake

## Operation
- FSM states and transitions:
  - IDLE → FEED on start when k_len>0.
  - IDLE → FLUSH on start when k_len==0.
  - FEED → FLUSH after the K-th accepted beat.
  - FLUSH → DRAIN after 2N−1 cycles.
  - DRAIN → IDLE after the handshake on row N−1.
- Accepted start clears all accumulators, skew registers and PE operand registers, latches k_len, and zeroes the beat and flush counters. start outside IDLE is ignored.
- Array moves only on "advance" = (FEED & in_valid & in_ready) | FLUSH. Nothing moves without advance (stall-safe).
- Skew: row lane i of in_d is delayed by i advance stages; column lane j of in_w is delayed by j stages. FLUSH injects zeros.
- PE(i,j): on advance, passes data right and weight down, and adds sign-extended data×weight to its accumulator. Operands of beat k are accumulated at PE(i,j) on advance number k+i+j+1 (beat 0 = advance 0).
- Arithmetic: signed DATA_WIDTH×DATA_WIDTH product (2*DATA_WIDTH bits), sign-extended to ACC_WIDTH; accumulation wraps modulo 2^ACC_WIDTH unless saturation is enabled (see Configuration).
- DRAIN: out_row = accumulator row r, out_row_idx = r, r from 0 to N−1, incremented on out_valid & out_ready. out_row and out_row_idx stay stable while out_ready is low.
- k_len==0: all rows drained as zero.

## Timing
- Reset values: busy=0, in_ready=0, out_valid=0, out_row=0, out_row_idx=0, done=0, state IDLE, all accumulators and pipeline registers 0.
- Reset asserted mid-job aborts immediately and returns all of the above to reset values.
- in_ready=1 exactly while in FEED; it is a registered state decode, not dependent on in_valid.
- out_valid=1 exactly while in DRAIN.
- Cycle schedule with no stalls:
  - start sampled at cycle 0.
  - FEED occupies cycles 1..K.
  - FLUSH occupies cycles K+1..K+2N−1.
  - Row 0 valid at cycle K+2N.
  - With out_ready held high, row N−1 handshakes at cycle K+3N−1.
  - done=1 at cycle K+3N, with busy=0 in the same cycle.
- done and a new start may coincide: the start is accepted (state already IDLE).

## Configuration
- SYSTOLIC_SAT_EN defined: each accumulate clamps to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1]. A saturated value stays clamped on further same-sign adds and can move back toward zero.
- Not defined: plain two's-complement wrap.

## Test plan
- Reset: assert rst_n low mid-FEED (N=4, K=4) → the same cycle, busy=0, in_ready=0, out_valid=0, out_row=0; the next job after reset gives correct results.
- Identity: N=4, K=4, B=I, A[i][k]=4i+k+1, no stalls → rows r=0..3 equal A row r (row 0 = 1,2,3,4); done at cycle 4+12=16 after start.
- Signed: N=4, K=4, all operands −128 → every C element = 65536; all operands −1 and +1 mixed with A=−1, B=+1 → every element = −4.
- Input stalls: the identity case with in_valid low on alternating cycles → identical rows; done 4 cycles later than the no-stall case.
- Output backpressure: out_ready low for 5 cycles on row 0 → out_row_idx=0 and out_row stable all 5 cycles, no done; after release, rows 1..3 follow in consecutive cycles.
- Saturation: ACC_WIDTH=16, K=4, all operands 127 → with SYSTOLIC_SAT_EN every element = 32767; without it, every element = −1020. k_len=0 job → 4 zero rows, done at cycle 3N after start.
